// File: rtl/lsu_mem_stage_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage_if
// Bundles every handshake and bus signal of the MIPS memory-access stage.
//   Request side  : in_valid/in_ready plus the captured operand fields.
//   Memory side   : mem_req/mem_ready word-wide req/ready bus.
//   Writeback side: wb_valid/wb_ready with destination register and data.
//   Exception side: single-cycle address-error pulse.
//   busy          : stage holds an access in flight.
// Modports:
//   slave  - the lsu_mem_stage view (consumes requests, drives memory/wb).
//   master - the surrounding pipeline / memory / writeback view.
// ---------------------------------------------------------------------------
interface lsu_mem_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int WB_RD_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic               in_store;
    logic [1:0]         in_size;
    logic               in_unsigned;
    logic [ADDR_W-1:0]  in_base;
    logic [15:0]        in_offset;
    logic [31:0]        in_wdata;
    logic [WB_RD_W-1:0] in_rd;

    logic               mem_req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [3:0]         mem_be;
    logic [31:0]        mem_wdata;
    logic               mem_ready;
    logic [31:0]        mem_rdata;

    logic               wb_valid;
    logic [WB_RD_W-1:0] wb_rd;
    logic [31:0]        wb_data;
    logic               wb_ready;

    logic               exc_valid;
    logic [ADDR_W-1:0]  exc_addr;
    logic               exc_store;

    logic               busy;

    modport slave (
        input  in_valid, in_store, in_size, in_unsigned, in_base, in_offset,
               in_wdata, in_rd, mem_ready, mem_rdata, wb_ready,
        output in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               wb_valid, wb_rd, wb_data, exc_valid, exc_addr, exc_store, busy
    );

    modport master (
        output in_valid, in_store, in_size, in_unsigned, in_base, in_offset,
               in_wdata, in_rd, mem_ready, mem_rdata, wb_ready,
        input  in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               wb_valid, wb_rd, wb_data, exc_valid, exc_addr, exc_store, busy
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
// Memory-access stage of the MIPS load/store path. Takes one load/store at a
// time, forms the effective address (base + sign-extended offset, wrapping),
// raises an address-error pulse for misaligned accesses, otherwise drives a
// word-wide little-endian data memory and hands extended load data to
// writeback.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-low
//   bus   - lsu_mem_stage_if.slave (request, memory, writeback, exception,
//           busy)
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int ADDR_W  = 32,
    parameter int WB_RD_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    lsu_mem_stage_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WB, EXC} state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [ADDR_W-1:0]  r_ea;
    logic               r_store;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [31:0]        r_wdata;
    logic [WB_RD_W-1:0] r_rd;
    logic [31:0]        r_wb_data;

    logic [ADDR_W-1:0]  w_ea;
    logic               w_misaligned;
    logic               w_accept;
    logic               w_load_done;
    logic               w_mem_req;
    logic               w_wb_valid;
    logic               w_exc_valid;
    logic               w_in_ready;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_rep;
    logic [7:0]         w_lane_b;
    logic [15:0]        w_lane_h;
    logic [31:0]        w_load_ext;

    // Effective address wraps modulo 2^ADDR_W; no overflow trap.
    assign w_ea = bus.in_base + {{(ADDR_W-16){bus.in_offset[15]}}, bus.in_offset};

    assign w_misaligned = (bus.in_size == 2'b11)
                       || (bus.in_size == 2'b01 && w_ea[0])
                       || (bus.in_size == 2'b10 && w_ea[1:0] != 2'b00);

    assign w_accept    = (r_state == IDLE) && bus.in_valid;
    assign w_load_done = (r_state == REQ) && bus.mem_ready && !r_store;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Captured request and latched load result.
    // NOTE: these registers are cleared by reset even though the FSM alone
    // would mask them, so every gated output is provably 0 after reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ea       <= '0;
            r_store    <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_wb_data  <= '0;
        end else begin
            if (w_accept) begin
                r_ea       <= w_ea;
                r_store    <= bus.in_store;
                r_size     <= bus.in_size;
                r_unsigned <= bus.in_unsigned;
                r_wdata    <= bus.in_wdata;
                r_rd       <= bus.in_rd;
            end
            if (w_load_done) begin
                r_wb_data <= w_load_ext;
            end
        end
    end

    // Byte enables and lane-replicated store data; memory sees whole words.
    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch forms.
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
        case (r_size)
            2'b00: begin
                w_be        = 4'b0001 << r_ea[1:0];
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = r_ea[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Little-endian lane select and sign/zero extension of load data.
    always_comb begin
        w_lane_b = bus.mem_rdata[7:0];
        case (r_ea[1:0])
            2'd1:    w_lane_b = bus.mem_rdata[15:8];
            2'd2:    w_lane_b = bus.mem_rdata[23:16];
            2'd3:    w_lane_b = bus.mem_rdata[31:24];
            default: ;
        endcase
        w_lane_h   = r_ea[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_load_ext = bus.mem_rdata;
        case (r_size)
            2'b00:   w_load_ext = {{24{~r_unsigned & w_lane_b[7]}}, w_lane_b};
            2'b01:   w_load_ext = {{16{~r_unsigned & w_lane_h[15]}}, w_lane_h};
            default: ;
        endcase
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_mem_req    = 1'b0;
        w_wb_valid   = 1'b0;
        w_exc_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = reset;
                if (bus.in_valid) begin
                    w_next_state = w_misaligned ? EXC : REQ;
                end
            end
            REQ: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    // A load to r0 still touches memory but skips writeback.
                    w_next_state = (r_store || r_rd == '0) ? IDLE : WB;
                end
            end
            WB: begin
                w_wb_valid = 1'b1;
                if (bus.wb_ready) begin
                    w_next_state = IDLE;
                end
            end
            EXC: begin
                w_exc_valid  = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Data outputs are gated by their strobes so idle/reset values are 0.
    assign bus.in_ready  = w_in_ready;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_req & r_store;
    assign bus.mem_addr  = w_mem_req ? {r_ea[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_be    = w_mem_req ? w_be : 4'b0000;
    assign bus.mem_wdata = w_mem_req ? w_wdata_rep : 32'h0;
    assign bus.wb_valid  = w_wb_valid;
    assign bus.wb_rd     = w_wb_valid ? r_rd : '0;
    assign bus.wb_data   = w_wb_valid ? r_wb_data : 32'h0;
    assign bus.exc_valid = w_exc_valid;
    assign bus.exc_addr  = w_exc_valid ? r_ea : '0;
    assign bus.exc_store = w_exc_valid & r_store;
    assign bus.busy      = (r_state != IDLE);
endmodule
